// File: rtl/ber_meter.sv
// Bit-error-rate meter: compares a received bit stream against a delayed copy
// of the transmitted reference over a programmable window of valid bits and
// reports the number of bits compared and the number of mismatches.
module ber_meter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned MAX_DLY = 15
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [CNT_W-1:0] window,
  input  logic [3:0]       dly,
  input  logic             bit_valid,
  input  logic             tx_bit,
  input  logic             rx_bit,
  output logic             busy,
  output logic             valid_o,
  output logic [CNT_W-1:0] sent_data,
  output logic [CNT_W-1:0] recv_data,
  output logic [CNT_W-1:0] number_of_bits
);

  localparam int unsigned TAP_W   = MAX_DLY + 1;
  localparam int unsigned IDX_W   = (TAP_W > 1) ? $clog2(TAP_W) : 1;
  localparam logic [3:0]  DLY_MAX = 4'(MAX_DLY);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_q,   win_d;
  logic [3:0]       dly_q,   dly_d;
  logic [3:0]       fill_q,  fill_d;
  logic [MAX_DLY-1:0] line_q, line_d;
  logic [CNT_W-1:0] bits_q,  bits_d;
  logic [CNT_W-1:0] errs_q,  errs_d;
  logic [CNT_W-1:0] sent_q,  sent_d;
  logic [CNT_W-1:0] recv_q,  recv_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             valid_q, valid_d;

  logic [TAP_W-1:0] tap;
  logic [IDX_W-1:0] dly_sel;
  logic [3:0]       dly_clamped;
  logic             tx_dly;
  logic             bit_err;
  logic [CNT_W-1:0] bits_inc;
  logic [3:0]       fill_inc;

  // Tap 0 is the current tx_bit, tap N the tx_bit accepted N valid cycles ago,
  // so dly=0 compares in the same cycle without a special case.
  assign tap         = {line_q, tx_bit};
  assign dly_sel     = dly_q[IDX_W-1:0];
  assign tx_dly      = tap[dly_sel];
  assign bit_err     = tx_dly ^ rx_bit;
  assign bits_inc    = bits_q + CNT_W'(1);
  assign fill_inc    = fill_q + 4'd1;
  assign dly_clamped = (dly > DLY_MAX) ? DLY_MAX : dly;

  // Next-state, counter and result logic.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    dly_d   = dly_q;
    fill_d  = fill_q;
    line_d  = line_q;
    bits_d  = bits_q;
    errs_d  = errs_q;
    sent_d  = sent_q;
    recv_d  = recv_q;
    nbits_d = nbits_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      FILL: begin
        if (bit_valid) begin
          line_d = tap[MAX_DLY-1:0];
        end
        if (dly_q == 4'd0) begin
          state_d = RUN;
        end else if (bit_valid) begin
          fill_d = fill_inc;
          if (fill_inc == dly_q) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bit_valid) begin
          line_d = tap[MAX_DLY-1:0];
        end
        if (bits_q == win_q) begin
          state_d = DONE;
        end else if (bit_valid) begin
          bits_d = bits_inc;
          errs_d = errs_q + CNT_W'(bit_err);
          if (bits_inc == win_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A start outside DONE overrides whatever the current state decided,
    // including a completion on this same edge, so aborted runs never report.
    if (start && (state_q != DONE)) begin
      state_d = FILL;
      win_d   = window;
      dly_d   = dly_clamped;
      fill_d  = '0;
      line_d  = '0;
      bits_d  = '0;
      errs_d  = '0;
    end

    // Results are loaded on the edge entering DONE so they appear together
    // with valid_o in the DONE cycle.
    if (state_d == DONE) begin
      valid_d = 1'b1;
      sent_d  = bits_d;
      recv_d  = errs_d;
      nbits_d = win_q;
    end
  end

  // State, delay line, counters and result registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      win_q   <= '0;
      dly_q   <= '0;
      fill_q  <= '0;
      line_q  <= '0;
      bits_q  <= '0;
      errs_q  <= '0;
      sent_q  <= '0;
      recv_q  <= '0;
      nbits_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      dly_q   <= dly_d;
      fill_q  <= fill_d;
      line_q  <= line_d;
      bits_q  <= bits_d;
      errs_q  <= errs_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
      nbits_q <= nbits_d;
      valid_q <= valid_d;
    end
  end

  assign busy           = (state_q == FILL) || (state_q == RUN);
  assign valid_o        = valid_q;
  assign sent_data      = sent_q;
  assign recv_data      = recv_q;
  assign number_of_bits = nbits_q;

endmodule

// File: tb/tb_ber_meter.sv
// Scoreboard bench for ber_meter: the driver builds each measurement from a
// list of accepted tx bits and pushes the expected result; a monitor pops and
// compares whenever valid_o is seen.
module tb_ber_meter;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned MAX_DLY = 7;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] window = '0;
  logic [3:0]       dly = '0;
  logic             bit_valid = 1'b0;
  logic             tx_bit = 1'b0;
  logic             rx_bit = 1'b0;
  logic             busy;
  logic             valid_o;
  logic [CNT_W-1:0] sent_data;
  logic [CNT_W-1:0] recv_data;
  logic [CNT_W-1:0] number_of_bits;

  ber_meter #(
    .CNT_W   (CNT_W),
    .MAX_DLY (MAX_DLY)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .start          (start),
    .window         (window),
    .dly            (dly),
    .bit_valid      (bit_valid),
    .tx_bit         (tx_bit),
    .rx_bit         (rx_bit),
    .busy           (busy),
    .valid_o        (valid_o),
    .sent_data      (sent_data),
    .recv_data      (recv_data),
    .number_of_bits (number_of_bits)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [CNT_W-1:0] sent;
    logic [CNT_W-1:0] errs;
    logic [CNT_W-1:0] nbits;
    int unsigned      at;
  } exp_t;

  exp_t        sb[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          mon_en = 1'b0;
  logic [CNT_W-1:0] last_s = '0, last_r = '0, last_n = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every valid_o must match the oldest pending expectation; between
  // pulses the result outputs must hold.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (valid_o === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got valid_o=1 expected 0 (no result pending) at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("sent_data",      64'(sent_data),      64'(e.sent));
          chk("recv_data",      64'(recv_data),      64'(e.errs));
          chk("number_of_bits", 64'(number_of_bits), 64'(e.nbits));
          chk("valid_cycle",    64'(cyc),            64'(e.at));
          chk("busy_in_done",   64'(busy),           64'(0));
        end
      end else begin
        chk("hold_sent",  64'(sent_data),      64'(last_s));
        chk("hold_recv",  64'(recv_data),      64'(last_r));
        chk("hold_nbits", 64'(number_of_bits), 64'(last_n));
      end
      last_s = sent_data;
      last_r = recv_data;
      last_n = number_of_bits;
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge CLK);
      start     = 1'b0;
      bit_valid = 1'($urandom);
      tx_bit    = 1'($urandom);
      rx_bit    = 1'($urandom);
    end
  endtask

  // One measurement. vpct: percent of valid cycles (0 = strict alternation).
  // epct: percent of compared bits flipped. stop_after: nonzero aborts the run
  // once that many valid bits have been supplied (the next start restarts it).
  task automatic run_meas(input logic [CNT_W-1:0] w, input logic [3:0] d,
                          input int unsigned vpct, input int unsigned epct,
                          input int unsigned stop_after);
    bit          txq[$];
    int unsigned dc, k, errs, c_last, total;
    bit          bv, flip, tog, aborted;
    exp_t        e;
    dc     = (int'(d) > MAX_DLY) ? MAX_DLY : int'(d);
    total  = dc + int'(w);
    k      = 0;
    errs   = 0;
    tog    = 1'b0;
    @(negedge CLK);
    start     = 1'b1;
    window    = w;
    dly       = d;
    bit_valid = 1'b0;
    tx_bit    = 1'($urandom);
    rx_bit    = 1'($urandom);
    @(negedge CLK);
    start     = 1'b0;
    bit_valid = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
    c_last = cyc;
    while (k < total && (stop_after == 0 || k < stop_after)) begin
      @(negedge CLK);
      if (vpct == 0) begin
        tog = ~tog;
        bv  = tog;
      end else begin
        bv = ($urandom_range(99) < vpct);
      end
      bit_valid = bv;
      tx_bit    = 1'($urandom);
      rx_bit    = 1'($urandom);
      if (bv) begin
        txq.push_back(tx_bit);
        if (k >= dc) begin
          flip   = ($urandom_range(99) < epct);
          rx_bit = txq[k - dc] ^ flip;
          if (flip) errs++;
        end
        k++;
        if (k == total) c_last = cyc;
      end
    end
    aborted = (stop_after != 0) && (stop_after < total);
    if (!aborted) begin
      e.sent  = w;
      e.errs  = CNT_W'(errs);
      e.nbits = w;
      e.at    = (w == 0) ? c_last + 2 : c_last + 1;
      sb.push_back(e);
    end
  endtask

  initial begin
    int unsigned guard;
    logic [CNT_W-1:0] rw;
    logic [3:0]       rd;
    int unsigned      rtot, rstop;

    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_busy",  64'(busy),           64'(0));
    chk("rst_valid", 64'(valid_o),        64'(0));
    chk("rst_sent",  64'(sent_data),      64'(0));
    chk("rst_recv",  64'(recv_data),      64'(0));
    chk("rst_nbits", 64'(number_of_bits), 64'(0));
    nRST   = 1'b1;
    mon_en = 1'b1;
    idle(3);

    run_meas(8, 4'd0, 100, 0, 0);     idle(4);
    run_meas(16, 4'd3, 100, 12, 0);   idle(4);
    run_meas(10, 4'd0, 0, 0, 0);      idle(4);
    run_meas(100, 4'd0, 100, 10, 40);
    run_meas(5, 4'd0, 100, 20, 0);    idle(4);
    run_meas(0, 4'd0, 100, 0, 0);     idle(4);
    run_meas(0, 4'd2, 70, 0, 0);      idle(4);
    run_meas(12, 4'd12, 80, 25, 0);   idle(4);
    run_meas(6, 4'd15, 100, 50, 0);   idle(4);

    for (int i = 0; i < 30; i++) begin
      rw    = CNT_W'($urandom_range(40, 1));
      rd    = 4'($urandom_range(15));
      rtot  = ((int'(rd) > MAX_DLY) ? MAX_DLY : int'(rd)) + int'(rw);
      rstop = ($urandom_range(4) == 0 && rtot > 1) ? $urandom_range(rtot - 1, 1) : 0;
      run_meas(rw, rd, $urandom_range(100, 30), $urandom_range(50), rstop);
      if (rstop == 0) idle($urandom_range(4, 2));
    end
    idle(4);

    // Asynchronous reset in the middle of a run.
    run_meas(50, 4'd2, 100, 10, 20);
    #2;
    mon_en = 1'b0;
    nRST   = 1'b0;
    #1;
    chk("midrst_busy",  64'(busy),           64'(0));
    chk("midrst_valid", 64'(valid_o),        64'(0));
    chk("midrst_sent",  64'(sent_data),      64'(0));
    chk("midrst_recv",  64'(recv_data),      64'(0));
    chk("midrst_nbits", 64'(number_of_bits), 64'(0));
    repeat (2) @(negedge CLK);
    nRST   = 1'b1;
    last_s = '0;
    last_r = '0;
    last_n = '0;
    mon_en = 1'b1;
    idle(20);
    chk("post_rst_busy", 64'(busy), 64'(0));
    run_meas(9, 4'd1, 60, 30, 0);

    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending results expected 0", sb.size());
    end
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ber_meter.md
BER_METER -- requirements
Module: ber_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of all count and window values.
REQ-002 SHALL have parameter MAX_DLY, default 15, largest supported tx-to-rx alignment delay in valid bits.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a measurement (from the switch debouncer pos output).
REQ-006 SHALL have port window  input  CNT_W  number of bits to compare; sampled on an accepted start.
REQ-007 SHALL have port dly  input  4  tx-to-rx delay in valid bits; sampled on an accepted start; values above MAX_DLY clamp to MAX_DLY.
REQ-008 SHALL have port bit_valid  input  1  qualifies tx_bit and rx_bit for the current cycle.
REQ-009 SHALL have port tx_bit  input  1  transmitted reference bit.
REQ-010 SHALL have port rx_bit  input  1  received bit.
REQ-011 SHALL have port busy  output  1  high while a measurement is in progress.
REQ-012 SHALL have port valid_o  output  1  one-cycle pulse; result outputs are valid from this cycle on.
REQ-013 SHALL have port sent_data  output  CNT_W  bits compared in the last completed measurement.
REQ-014 SHALL have port recv_data  output  CNT_W  bit errors in the last completed measurement.
REQ-015 SHALL have port number_of_bits  output  CNT_W  window used in the last completed measurement.

Function
REQ-016 SHALL implement states IDLE, FILL, RUN, DONE; IDLE after reset.
REQ-017 In IDLE, start SHALL latch window and clamped dly, clear the delay line and internal counters, and go to FILL; busy rises the next cycle.
REQ-018 tx_bit SHALL pass through a shift line advanced only on bit_valid, so each rx_bit compares against the tx_bit accepted dly valid cycles earlier; dly=0 compares in the same cycle.
REQ-019 FILL SHALL count dly valid bits without comparing, then go to RUN; dly=0 SHALL go directly to RUN after one cycle.
REQ-020 In RUN, each bit_valid cycle SHALL increment the bit count by 1 and the error count by (delayed tx_bit XOR rx_bit).
REQ-021 When the bit count reaches the latched window, RUN SHALL go to DONE on that same edge; no further bits are counted.
REQ-022 window=0 SHALL complete with zero counts: IDLE->FILL->(RUN)->DONE with no bits counted in RUN.
REQ-023 DONE SHALL last one cycle: copy counts and window to sent_data/recv_data/number_of_bits, pulse valid_o, drop busy, return to IDLE.
REQ-024 The valid_o pulse and the new result values SHALL appear in the same cycle; latency from the final counted bit edge to valid_o is one cycle.
REQ-025 Result outputs SHALL hold between measurements and SHALL NOT change during FILL or RUN.
REQ-026 start during FILL or RUN SHALL abort and restart: relatch inputs, clear line and counters, enter FILL; no valid_o for the aborted run.
REQ-027 start in the DONE cycle SHALL be ignored.
REQ-028 Counters SHALL be CNT_W wide; error count never exceeds bit count, which never exceeds window, so no wrap-around is possible.
REQ-029 bit_valid low SHALL freeze the delay line, FILL counter and RUN counters.

Reset
REQ-030 nRST low SHALL immediately force IDLE, busy=0, valid_o=0, sent_data=recv_data=number_of_bits=0, and clear delay line and counters, including mid-measurement.
REQ-031 After nRST rises, no measurement SHALL begin until a new start pulse.

Verification
REQ-032 window=8, dly=0, tx=rx on 8 consecutive valid cycles -> valid_o one cycle after the 8th bit; sent_data=8, recv_data=0, number_of_bits=8.
REQ-033 window=16, dly=3, rx equals tx delayed 3 bits except 2 flipped bits -> sent_data=16, recv_data=2; first 3 valid cycles not counted.
REQ-034 window=10, bit_valid toggling every other cycle -> valid_o after the 10th valid bit (about 20 cycles); counts 10/0.
REQ-035 window=100, start re-pulsed after 40 bits with window=5 -> single valid_o only, number_of_bits=5, sent_data=5.
REQ-036 window=0 -> valid_o within 3 cycles of start, all result outputs 0 except number_of_bits=0.
REQ-037 nRST pulsed low mid-RUN -> busy, valid_o and all results 0 asynchronously; no valid_o afterwards without new start.
